// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit and the ALU control decoder.
package uc_pkg;

  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned ALU_CMD_W = 4;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CLASS_W   = 3;

  // Major opcodes recognised by the control unit
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;

  // alu_cmd encodings consumed by the ALU control decoder
  localparam logic [ALU_CMD_W-1:0] ALU_RTYPE = 4'b0000;
  localparam logic [ALU_CMD_W-1:0] ALU_ITYPE = 4'b0001;
  localparam logic [ALU_CMD_W-1:0] ALU_STYPE = 4'b0010;
  localparam logic [ALU_CMD_W-1:0] ALU_BTYPE = 4'b0011;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_NONE   = 3'd7
  } op_class_e;

  // ALU command issued while an instruction of the given class is in EXEC/MEM
  function automatic logic [ALU_CMD_W-1:0] alu_cmd_of(input op_class_e cls);
    logic [ALU_CMD_W-1:0] cmd;
    case (cls)
      CLS_R:      cmd = ALU_RTYPE;
      CLS_STORE:  cmd = ALU_STYPE;
      CLS_BRANCH: cmd = ALU_BTYPE;
      default:    cmd = ALU_ITYPE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/uc_opdecode.sv
// Opcode classifier: maps opcode/funct3 to an instruction class and a legality flag.
// Optional feature: define MULTICYCLE_JAL_EN to accept jal (1101111).
module uc_opdecode
  import uc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] op_class_c,
  output logic       legal_c
);

  // Pure combinational classification; unknown encodings report CLS_NONE / illegal
  always_comb begin
    op_class_c = 3'(CLS_NONE);
    legal_c    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        op_class_c = 3'(CLS_R);
        legal_c    = 1'b1;
      end
      OP_ITYPE: begin
        op_class_c = 3'(CLS_I);
        legal_c    = 1'b1;
      end
      OP_LOAD: begin
        op_class_c = 3'(CLS_LOAD);
        legal_c    = 1'b1;
      end
      OP_STORE: begin
        op_class_c = 3'(CLS_STORE);
        legal_c    = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          op_class_c = 3'(CLS_BRANCH);
          legal_c    = 1'b1;
        end
      end
`ifdef MULTICYCLE_JAL_EN
      OP_JAL: begin
        op_class_c = 3'(CLS_JAL);
        legal_c    = 1'b1;
      end
`endif
      default: begin
        op_class_c = 3'(CLS_NONE);
        legal_c    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM with memory-wait timeout and sticky halt.
// Optional feature: define MULTICYCLE_JAL_EN to execute jal in 3 cycles.
module multicycle_control
  import uc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [2:0] state
);

  // Counter only needs to reach MEM_TIMEOUT-1 before the fault fires
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_e            state_q, state_d;
  op_class_e         cls_q, cls_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              halted_q, halted_d;

  logic [2:0] dec_class_c;
  logic       dec_legal_c;
  logic       timeout_hit_c;

  uc_opdecode u_opdecode (
    .opcode     (opcode),
    .funct3     (funct3),
    .op_class_c (dec_class_c),
    .legal_c    (dec_legal_c)
  );

  // Next-state, class capture and consecutive-wait counting
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    wait_d        = '0;
    halted_d      = halted_q;
    timeout_hit_c = (MEM_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT);
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)          state_d = ST_DECODE;
        else if (timeout_hit_c) state_d = ST_HALT;
        else                    wait_d  = wait_q + WAIT_W'(1);
      end
      ST_DECODE: begin
        cls_d   = op_class_e'(dec_class_c);
        state_d = dec_legal_c ? ST_EXEC : ST_HALT;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_I:         state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BRANCH, CLS_JAL:  state_d = ST_FETCH;
          default:              state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)          state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout_hit_c) state_d = ST_HALT;
        else                    wait_d  = wait_q + WAIT_W'(1);
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    if (state_d == ST_HALT) halted_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      cls_q    <= CLS_NONE;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  // Moore outputs from state/class, with handshake- and zero-qualified strobes; quiet in reset
  always_comb begin
    alu_cmd    = ALU_ITYPE;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_EXEC: begin
          alu_cmd = alu_cmd_of(cls_q);
          alu_src = (cls_q == CLS_I) || (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);
          if ((cls_q == CLS_BRANCH) && zero) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          if (cls_q == CLS_JAL) begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
          end
        end
        ST_MEM: begin
          alu_cmd   = alu_cmd_of(cls_q);
          mem_read  = (cls_q == CLS_LOAD);
          mem_write = (cls_q == CLS_STORE);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == CLS_LOAD);
        end
        default: begin
          alu_cmd = ALU_ITYPE;
        end
      endcase
    end
  end

  assign halted = halted_q;
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control (MEM_TIMEOUT = 15).
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_cmd;
  logic       mem_read, mem_write, ir_write, pc_write, pc_src;
  logic       alu_src, reg_write, mem_to_reg, halted;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  localparam logic [3:0] A_R = 4'b0000, A_I = 4'b0001, A_S = 4'b0010, A_B = 4'b0011;

  // strobe order: mem_read mem_write ir_write pc_write pc_src alu_src reg_write mem_to_reg
  localparam logic [7:0] SB_0   = 8'b0000_0000;
  localparam logic [7:0] SB_FW  = 8'b1000_0000;
  localparam logic [7:0] SB_FD  = 8'b1011_0000;
  localparam logic [7:0] SB_EXI = 8'b0000_0100;
  localparam logic [7:0] SB_BR  = 8'b0001_1000;
  localparam logic [7:0] SB_LD  = 8'b1000_0000;
  localparam logic [7:0] SB_ST  = 8'b0100_0000;
  localparam logic [7:0] SB_WBR = 8'b0000_0010;
  localparam logic [7:0] SB_WBL = 8'b0000_0011;
  localparam logic [7:0] SB_JAL = 8'b0001_1010;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_cmd    (alu_cmd),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .halted     (halted),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic [2:0] st, input logic [3:0] alu,
                                     input logic [7:0] sb, input logic h);
    return {st, alu, sb, h};
  endfunction

  // Drive one cycle of inputs after the falling edge, queue the expectation, then sample and compare
  task automatic cyc(input string tag, input logic rst, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic rdy, input logic [15:0] expv);
    logic [15:0] obs;
    logic [15:0] want;
    string       t;
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    funct3    = f3;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    #1;
    obs  = {state, alu_cmd, mem_read, mem_write, ir_write, pc_write, pc_src,
            alu_src, reg_write, mem_to_reg, halted};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", t, obs, want);
    end
  endtask

  // Zero-wait fetch followed by decode
  task automatic run_fd(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic z);
    cyc({tag, "_fetch"},  1'b0, op, f3, z, 1'b1, ev(S_F, A_I, SB_FD, 1'b0));
    cyc({tag, "_decode"}, 1'b0, op, f3, z, 1'b1, ev(S_D, A_I, SB_0, 1'b0));
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc("rst_hold", 1'b1, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_F, A_I, SB_0, 1'b0));

    // add: 0,1,2,4
    run_fd("add", OP_ADD, 3'b000, 1'b0);
    cyc("add_exec", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_E, A_R, SB_0, 1'b0));
    cyc("add_wb",   1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_W, A_I, SB_WBR, 1'b0));

    // addi
    run_fd("addi", OP_ADDI, 3'b000, 1'b0);
    cyc("addi_exec", 1'b0, OP_ADDI, 3'b000, 1'b0, 1'b1, ev(S_E, A_I, SB_EXI, 1'b0));
    cyc("addi_wb",   1'b0, OP_ADDI, 3'b000, 1'b0, 1'b1, ev(S_W, A_I, SB_WBR, 1'b0));

    // lw with three wait cycles in MEM
    run_fd("lw", OP_LW, 3'b000, 1'b0);
    cyc("lw_exec", 1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_E, A_I, SB_EXI, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", 1'b0, OP_LW, 3'b000, 1'b0, 1'b0, ev(S_M, A_I, SB_LD, 1'b0));
    cyc("lw_mem_done", 1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_M, A_I, SB_LD, 1'b0));
    cyc("lw_wb",       1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_W, A_I, SB_WBL, 1'b0));

    // sw zero-wait
    run_fd("sw", OP_SW, 3'b000, 1'b0);
    cyc("sw_exec", 1'b0, OP_SW, 3'b000, 1'b0, 1'b1, ev(S_E, A_S, SB_EXI, 1'b0));
    cyc("sw_mem",  1'b0, OP_SW, 3'b000, 1'b0, 1'b1, ev(S_M, A_S, SB_ST, 1'b0));

    // beq taken then not taken
    run_fd("beq_t", OP_BEQ, 3'b000, 1'b1);
    cyc("beq_t_exec", 1'b0, OP_BEQ, 3'b000, 1'b1, 1'b1, ev(S_E, A_B, SB_BR, 1'b0));
    run_fd("beq_nt", OP_BEQ, 3'b000, 1'b0);
    cyc("beq_nt_exec", 1'b0, OP_BEQ, 3'b000, 1'b0, 1'b1, ev(S_E, A_B, SB_0, 1'b0));

    // Fetch ready on the 15th cycle: completes without fault
    for (int i = 0; i < 14; i++)
      cyc("fetch_wait", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));
    cyc("fetch_15th_ready", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_F, A_I, SB_FD, 1'b0));
    cyc("fetch_15th_decode", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_D, A_I, SB_0, 1'b0));
    cyc("fetch_15th_exec",   1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_E, A_R, SB_0, 1'b0));
    cyc("fetch_15th_wb",     1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_W, A_I, SB_WBR, 1'b0));

    // Counter clears between FETCH and MEM: 10 + 14 waits never fault
    for (int i = 0; i < 10; i++)
      cyc("lw2_fetch_wait", 1'b0, OP_LW, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));
    run_fd("lw2", OP_LW, 3'b000, 1'b0);
    cyc("lw2_exec", 1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_E, A_I, SB_EXI, 1'b0));
    for (int i = 0; i < 14; i++)
      cyc("lw2_mem_wait", 1'b0, OP_LW, 3'b000, 1'b0, 1'b0, ev(S_M, A_I, SB_LD, 1'b0));
    cyc("lw2_mem_15th_ready", 1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_M, A_I, SB_LD, 1'b0));
    cyc("lw2_wb",             1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_W, A_I, SB_WBL, 1'b0));

    // sw MEM timeout -> HALT
    run_fd("sw_to", OP_SW, 3'b000, 1'b0);
    cyc("sw_to_exec", 1'b0, OP_SW, 3'b000, 1'b0, 1'b1, ev(S_E, A_S, SB_EXI, 1'b0));
    for (int i = 0; i < 15; i++)
      cyc("sw_to_mem_wait", 1'b0, OP_SW, 3'b000, 1'b0, 1'b0, ev(S_M, A_S, SB_ST, 1'b0));
    cyc("mem_timeout_halt", 1'b0, OP_SW, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
    cyc("rst_from_halt",    1'b1, OP_SW, 3'b000, 1'b0, 1'b0, ev(S_H, A_I, SB_0, 1'b1));

    // Fetch timeout after 15 wait cycles
    cyc("post_rst_fetch", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));
    for (int i = 0; i < 14; i++)
      cyc("fetch_to_wait", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));
    cyc("fetch_timeout_halt", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
    cyc("rst_fetch_to",       1'b1, OP_ADD, 3'b000, 1'b0, 1'b0, ev(S_H, A_I, SB_0, 1'b1));

    // Branch with funct3 != 000 is illegal
    run_fd("bne", OP_BEQ, 3'b001, 1'b0);
    cyc("bne_halt", 1'b0, OP_BEQ, 3'b001, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
    cyc("rst_bne",  1'b1, OP_BEQ, 3'b001, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));

    // Illegal opcode: HALT persists 10 cycles, reset recovers
    run_fd("bad", OP_BAD, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("bad_halt_sticky", 1'b0, OP_BAD, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
    cyc("rst_bad", 1'b1, OP_BAD, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));

    // Reset mid-MEM of sw: store strobe quiet, FETCH follows
    run_fd("sw_rst", OP_SW, 3'b000, 1'b0);
    cyc("sw_rst_exec", 1'b0, OP_SW, 3'b000, 1'b0, 1'b1, ev(S_E, A_S, SB_EXI, 1'b0));
    for (int i = 0; i < 2; i++)
      cyc("sw_rst_mem_wait", 1'b0, OP_SW, 3'b000, 1'b0, 1'b0, ev(S_M, A_S, SB_ST, 1'b0));
    cyc("sw_rst_pulse", 1'b1, OP_SW, 3'b000, 1'b0, 1'b0, ev(S_M, A_I, SB_0, 1'b0));
    cyc("sw_rst_after", 1'b0, OP_SW, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));

    // Reset mid-MEM of lw with mem_ready high: access aborted, no WB
    run_fd("lw_rst", OP_LW, 3'b000, 1'b0);
    cyc("lw_rst_exec", 1'b0, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_E, A_I, SB_EXI, 1'b0));
    cyc("lw_rst_mem",  1'b0, OP_LW, 3'b000, 1'b0, 1'b0, ev(S_M, A_I, SB_LD, 1'b0));
    cyc("lw_rst_pulse", 1'b1, OP_LW, 3'b000, 1'b0, 1'b1, ev(S_M, A_I, SB_0, 1'b0));
    cyc("lw_rst_after", 1'b0, OP_LW, 3'b000, 1'b0, 1'b0, ev(S_F, A_I, SB_FW, 1'b0));

    // jal: accepted only when the feature is built in
    run_fd("jal", OP_JAL, 3'b000, 1'b0);
`ifdef MULTICYCLE_JAL_EN
    cyc("jal_exec",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, ev(S_E, A_I, SB_JAL, 1'b0));
    cyc("jal_fetch", 1'b0, OP_ADD, 3'b000, 1'b0, 1'b1, ev(S_F, A_I, SB_FD, 1'b0));
`else
    cyc("jal_halt",   1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
    cyc("jal_halt_2", 1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, ev(S_H, A_I, SB_0, 1'b1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
